tag_table_ram: RTL and testbench

//  Single-port distributed RAM holding the cache tag table: one {dirty,valid,tag[11:0]}

---
 rtl/tag_table_ram.sv | 58 +++++
 tb/tb_tag_table_ram.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/tag_table_ram.sv
// Cache tag table: single-port distributed RAM with asynchronous read, synchronous write
// and a reset-triggered sweep that clears every entry before the RAM is usable again.
module tag_table_ram #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  we,
  output logic                  ready
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Power-up lands directly in RUN with an all-zero table; only rst starts a sweep.
  state_t                state   = RUN;
  logic                  ready_q = 1'b1;
  logic [ADDR_WIDTH:0]   cnt     = '0;
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      ready_q <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        CLEAR: begin
          mem[cnt[ADDR_WIDTH-1:0]] <= '0;
          cnt <= cnt + (ADDR_WIDTH + 1)'(1);
          if (cnt[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}}) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (we && ready_q) mem[addr] <= din;
        end
        default: state <= RUN;
      endcase
    end
  end

  // Lines mid-sweep must look invalid to the controller, whatever they held before.
  assign dout  = (state == CLEAR) ? '0 : mem[addr];
  assign ready = ready_q;

  assert property (@(posedge clk) disable iff (rst) ready_q |-> !$isunknown(we));

endmodule

// File: tb/tb_tag_table_ram.sv
// Self-checking bench for tag_table_ram: shadow model plus expected-value scoreboard queue.
module tb_tag_table_ram;

  localparam int AW = 14;
  localparam int DW = 14;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          we = 1'b0;
  logic          ready;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    string         tag;
    logic [DW-1:0] value;
  } expect_t;

  expect_t       sbQ[$];
  logic [DW-1:0] model [int];

  tag_table_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .din  (din),
    .dout (dout),
    .we   (we),
    .ready(ready)
  );

  always #5 clk = ~clk;

  // Single point of comparison: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] modelRead(input int a);
    return model.exists(a) ? model[a] : '0;
  endfunction

  task automatic pushExpect(input string tag, input logic [DW-1:0] value);
    expect_t e;
    e.tag   = tag;
    e.value = value;
    sbQ.push_back(e);
  endtask

  task automatic popCompare();
    expect_t e;
    if (sbQ.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sbQ.pop_front();
      checkOutput(e.tag, 32'(dout), 32'(e.value));
    end
  endtask

  // Combinational read between edges: drive addr, let it settle, compare with the model.
  task automatic readCheck(input string tag, input logic [AW-1:0] a);
    addr = a;
    pushExpect(tag, modelRead(int'(a)));
    #1;
    popCompare();
  endtask

  // One write cycle: old value visible before the edge, new value right after it.
  task automatic applyStimulus(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    addr = a;
    din  = d;
    we   = 1'b1;
    pushExpect({tag, "_pre"}, modelRead(int'(a)));
    #1;
    popCompare();
    @(posedge clk);
    model[int'(a)] = d;
    pushExpect({tag, "_post"}, d);
    #1;
    popCompare();
    we = 1'b0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_low_after_rst", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts rising edges until ready returns; a blown budget counts as a failure.
  task automatic waitReady(input int startCycles, output int cycles);
    cycles = startCycles;
    while (ready !== 1'b1 && cycles <= DEPTH + 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (ready !== 1'b1) checkOutput("ready_timeout", 32'(ready), 32'd1);
  endtask

  logic [AW-1:0] fillAddr [8] = '{14'h0000, 14'h0005, 14'h0123, 14'h0800,
                                  14'h1FFF, 14'h2345, 14'h3FF0, 14'h3FFF};
  int cyc;

  initial begin
    #2;
    checkOutput("powerup_ready", 32'(ready), 32'd1);
    readCheck("powerup_0000", 14'h0000);
    readCheck("powerup_1fff", 14'h1FFF);
    readCheck("powerup_3fff", 14'h3FFF);

    applyStimulus("wr_0123", 14'h0123, 14'h3ABC);
    applyStimulus("wr_3fff", 14'h3FFF, 14'h1001);

    @(negedge clk);
    readCheck("async_0123", 14'h0123);
    readCheck("async_3fff", 14'h3FFF);
    readCheck("async_0000", 14'h0000);
    readCheck("async_0123_again", 14'h0123);

    foreach (fillAddr[i]) applyStimulus($sformatf("fill_%0d", i), fillAddr[i], DW'(14'h1111 * (i + 1)));

    pulseReset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    addr = 14'h3FF0;
    we   = 1'b0;
    pushExpect("clear_dout_forced", '0);
    #1;
    popCompare();
    addr = 14'h0005;
    din  = 14'h2AAA;
    we   = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("clear_ready_low", 32'(ready), 32'd0);
    we = 1'b0;
    waitReady(11, cyc);
    checkOutput("sweep_cycles", 32'(cyc), 32'(DEPTH));
    model.delete();
    @(negedge clk);
    foreach (fillAddr[i]) readCheck($sformatf("cleared_%0d", i), fillAddr[i]);

    applyStimulus("wr_after_clear", 14'h0777, 14'h1ABC);

    pulseReset();
    repeat (5000) @(posedge clk);
    checkOutput("midsweep_ready_low", 32'(ready), 32'd0);
    pulseReset();
    waitReady(0, cyc);
    checkOutput("restart_sweep_cycles", 32'(cyc), 32'(DEPTH));
    model.delete();
    @(negedge clk);
    readCheck("restart_cleared_0777", 14'h0777);

    applyStimulus("nb_003f", 14'h003F, 14'h0A5A);
    applyStimulus("nb_0041", 14'h0041, 14'h15A5);
    applyStimulus("b2b_first", 14'h0040, 14'h2001);
    applyStimulus("b2b_second", 14'h0040, 14'h3002);
    @(negedge clk);
    readCheck("b2b_final_0040", 14'h0040);
    readCheck("b2b_nb_003f", 14'h003F);
    readCheck("b2b_nb_0041", 14'h0041);

    if (sbQ.size() != 0) checkOutput("scoreboard_leftover", 32'(sbQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
